// File: rtl/three_parallel_crc_checker_pkg.sv
// Shared definitions for the 3-parallel CRC link: defaults, beat count, FSM states
// and the single-bit LFSR step used by both encoder and checker.
package three_par_crc_pkg;

    localparam int             DEF_CRC_W    = 9;
    localparam logic [8:0]     DEF_POLY     = 9'h119;
    localparam int             DEF_MSG_BITS = 9;

    typedef enum logic {RUN, DONE} state_e;

    function automatic int calc_beats(input int msg_bits, input int crc_w);
        return (msg_bits + crc_w) / 3;
    endfunction

    // One serial shift of a w-bit remainder held in the low bits of a 32-bit word.
    function automatic logic [31:0] crc_step1(input logic [31:0] rem, input logic b,
                                              input logic [31:0] poly, input int w);
        logic [31:0] mask;
        logic        fb;
        mask = (32'h1 << w) - 32'h1;
        fb   = rem[5'(w - 1)] ^ b;
        return ((rem << 1) ^ (fb ? poly : 32'h0)) & mask;
    endfunction

endpackage

// File: rtl/three_parallel_crc_checker_if.sv
// Beat input and result output handshake bundle of the 3-parallel CRC checker.
interface three_parallel_crc_checker_if #(parameter int CRC_W = 9);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic             crc_ok;
    logic [CRC_W-1:0] syndrome;
    logic [7:0]       err_cnt;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, crc_ok, syndrome, err_cnt);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, crc_ok, syndrome, err_cnt);
endinterface

// File: rtl/three_parallel_crc_checker_crc3_step.sv
// Combinational 3-bit unrolled LFSR divider step; in_data[2] is shifted in first.
module crc3_step
    import three_par_crc_pkg::*;
#(
    parameter int               CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = DEF_POLY
) (
    input  logic [CRC_W-1:0] i_rem,
    input  logic [2:0]       i_data,
    output logic [CRC_W-1:0] o_rem
);
    logic [CRC_W-1:0] w_r [0:3];

    assign w_r[0] = i_rem;
    for (genvar k = 0; k < 3; k++) begin : g_step
        assign w_r[k+1] = CRC_W'(crc_step1(32'(w_r[k]), i_data[2-k], 32'(POLY), CRC_W));
    end
    assign o_rem = w_r[3];
endmodule

// File: rtl/three_parallel_crc_checker.sv
// Receive-side 3-parallel CRC checker: RUN/DONE FSM, beat counter, result registers.
// Optional saturating failed-frame counter enabled by THREE_PAR_CRC_ERR_CNT_EN.
module three_parallel_crc_checker
    import three_par_crc_pkg::*;
#(
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = DEF_POLY,
    parameter int               MSG_BITS = DEF_MSG_BITS
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    three_parallel_crc_checker_if.slave  bus
);
    localparam int BEATS = calc_beats(MSG_BITS, CRC_W);
    localparam int CNT_W = $clog2(BEATS + 1);

    if ((MSG_BITS + CRC_W) % 3 != 0) begin : g_bad_frame
        $error("MSG_BITS+CRC_W must be a multiple of 3");
    end

    state_e           r_state;
    logic [CRC_W-1:0] r_rem;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_out_valid;
    logic             r_crc_ok;
    logic [CRC_W-1:0] r_syndrome;
    logic [CRC_W-1:0] w_next_rem;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;

    crc3_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .i_rem  (r_rem),
        .i_data (bus.in_data),
        .o_rem  (w_next_rem)
    );

    assign w_in_ready = (r_state == RUN) && !i_flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RUN;
            r_rem       <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_syndrome  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_flush) begin
                        r_rem      <= '0;
                        r_beat_cnt <= '0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_crc_ok    <= (w_next_rem == '0);
                            r_syndrome  <= w_next_rem;
                            r_rem       <= '0;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_rem      <= w_next_rem;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result held until taken; flush has no effect here.
                    if (bus.out_ready) begin
                        r_state     <= RUN;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef THREE_PAR_CRC_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err_cnt <= 8'h00;
        else if (w_accept && w_last && (w_next_rem != '0) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'h01;
    end
    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.crc_ok    = r_crc_ok;
    assign bus.syndrome  = r_syndrome;
endmodule

// File: tb/tb_three_parallel_crc_checker.sv
// Scoreboard bench for the 3-parallel CRC checker; reference is polynomial long division.
module tb_three_parallel_crc_checker;
    import three_par_crc_pkg::*;

    localparam int CW    = DEF_CRC_W;
    localparam int MB    = DEF_MSG_BITS;
    localparam int NB    = CW + MB;
    localparam int BEATS = NB / 3;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    three_parallel_crc_checker_if #(.CRC_W(CW)) bus ();

    three_parallel_crc_checker #(.CRC_W(CW), .POLY(DEF_POLY), .MSG_BITS(MB)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .bus     (bus)
    );

    typedef struct {
        logic          ok;
        logic [CW-1:0] syn;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            err_model = 0;
    bit            rnd_ordy = 0;
    bit            hold_v = 0;
    logic          h_ok;
    logic [CW-1:0] h_syn;

    // Remainder of v modulo the generator x^CW + POLY, by long division over GF(2).
    function automatic logic [CW-1:0] polymod(input logic [63:0] v);
        logic [63:0] g;
        g = 64'(DEF_POLY) | (64'h1 << CW);
        for (int i = 63; i >= CW; i--)
            if (v[i]) v = v ^ (g << (i - CW));
        return v[CW-1:0];
    endfunction

    // The checker divides the codeword shifted up by CW (its LFSR feeds bits at the top).
    function automatic logic [CW-1:0] syndrome_of(input logic [NB-1:0] cw);
        return polymod(64'(cw) << CW);
    endfunction

    function automatic logic [NB-1:0] encode(input logic [MB-1:0] msg);
        return {msg, polymod(64'(msg) << CW)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            check("in_ready_while_done", 32'(bus.in_ready), 32'h0);
            if (hold_v) begin
                check("hold_crc_ok", 32'(bus.crc_ok), 32'(h_ok));
                check("hold_syndrome", 32'(bus.syndrome), 32'(h_syn));
            end
            if (bus.out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got syndrome %0h expected no result", bus.syndrome);
                end else begin
                    e = q.pop_front();
                    check("crc_ok", 32'(bus.crc_ok), 32'(e.ok));
                    check("syndrome", 32'(bus.syndrome), 32'(e.syn));
                end
                hold_v = 0;
            end else begin
                hold_v = 1;
                h_ok   = bus.crc_ok;
                h_syn  = bus.syndrome;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ordy) bus.out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ordy(input logic v);
        @(posedge clk);
        #1;
        bus.out_ready = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        hold_v = 0;
        err_model = 0;
    endtask

    task automatic beat(input logic [2:0] d, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        ok = (t < 200);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: got in_ready 0 expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [NB-1:0] cw, input int flush_at, input bit gaps);
        bit            ok;
        logic [CW-1:0] s;
        for (int b = 0; b < BEATS; b++) begin
            if (b == flush_at) begin
                @(negedge clk);
                flush = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = 3'($urandom);
                #1;
                check("flush_in_ready", 32'(bus.in_ready), 32'h0);
                @(negedge clk);
                flush = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            beat(cw[NB-1-3*b -: 3], ok);
            if (!ok) return;
        end
        s = syndrome_of(cw);
        q.push_back('{ok: (s == '0), syn: s});
        if (s != '0 && err_model < 255) err_model++;
        @(negedge clk);
        check("latency_out_valid", 32'(bus.out_valid), 32'h1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", 32'(q.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_err(input string name);
`ifdef THREE_PAR_CRC_ERR_CNT_EN
        check(name, 32'(bus.err_cnt), 32'(err_model));
`else
        check(name, 32'(bus.err_cnt), 32'h0);
`endif
    endtask

    initial begin
        logic [NB-1:0] cw;
        bit            ok;
        bus.in_valid  = 1'b0;
        bus.in_data   = 3'b000;
        bus.out_ready = 1'b1;
        flush = 1'b0;
        reset = 1'b1;
        do_reset();
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_crc_ok", 32'(bus.crc_ok), 32'h0);
        check("rst_syndrome", 32'(bus.syndrome), 32'h0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);

        send_frame('0, -1, 0);
        send_frame(NB'(1), -1, 0);
        send_frame(NB'(2), -1, 0);

        cw = encode(9'b101011010);
        send_frame(cw, -1, 0);
        for (int k = 0; k < NB; k++) send_frame(cw ^ (NB'(1) << k), -1, 0);
        drain();

        // Result back-pressure: result must hold and input must stall.
        set_ordy(1'b0);
        send_frame(encode(MB'($urandom)) ^ NB'(4), -1, 0);
        repeat (5) @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        set_ordy(1'b1);
        send_frame(encode(MB'($urandom)), -1, 0);
        drain();

        send_frame(encode(MB'($urandom)) ^ NB'(1), 3, 0);
        send_frame('0, -1, 0);
        drain();
        check_err("err_cnt_directed");

        // Partial frame cut by reset yields nothing.
        for (int b = 0; b < 3; b++) beat(3'b101, ok);
        do_reset();
        send_frame('0, -1, 0);
        drain();

        rnd_ordy = 1;
        for (int n = 0; n < 60; n++) begin
            cw = encode(MB'($urandom));
            if ($urandom_range(0, 1) != 0) cw = cw ^ NB'($urandom);
            send_frame(cw, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BEATS-1)) : -1, 1);
        end
        rnd_ordy = 0;
        set_ordy(1'b1);
        drain();
        check_err("err_cnt_random");

        for (int n = 0; n < 300; n++) send_frame(encode(MB'($urandom)) ^ NB'(1), -1, 0);
        drain();
        check_err("err_cnt_saturate");
        do_reset();
        check("err_cnt_after_reset", 32'(bus.err_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
